// File: rtl/pacoblaze_regfile_arbiter_pkg.sv
// Shared definitions for the PacoBlaze register-file X-port arbiter:
// FSM state encoding, default geometry and starvation limit.
// Default geometry follows `REGISTER_DEPTH / `REGISTER_WIDTH when the
// surrounding core defines them, otherwise 16 x 8-bit.

`ifndef REGISTER_DEPTH
`define REGISTER_DEPTH 4
`endif

`ifndef REGISTER_WIDTH
`define REGISTER_WIDTH 8
`endif

package pacoblaze_regfile_arbiter_pkg;

  // Arbiter FSM: normal port sharing, or the zeroing sweep.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

  localparam int DEF_DEPTH_W      = `REGISTER_DEPTH;
  localparam int DEF_DATA_W       = `REGISTER_WIDTH;
  localparam int DEF_STARVE_LIMIT = 7;

  // Starve counter width; STARVE_LIMIT must fit (1..255).
  localparam int STARVE_W = 8;

endpackage

// File: rtl/pacoblaze_regfile_arbiter_starve_counter.sv
// pacoblaze_starve_counter: saturating 8-bit wait counter for the host
// requester. Counts cycles the host has waited while the core held the
// X port; tc_o tells the arbiter to steal one cycle from the core.

module pacoblaze_starve_counter
  import pacoblaze_regfile_arbiter_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/pacoblaze_regfile_arbiter.sv
// pacoblaze_regfile_arbiter: owns the X (read/write) port of the PacoBlaze
// register file. Shares it between the core and a host/debug requester
// with bounded host starvation, and runs a sweep that zeroes every
// register. The Y read port does not pass through this block.
//
// Build option: PACOBLAZE_CLEAR_ON_RESET_EN
//   defined   - leave reset in CLEAR, zeroing the file before the core runs
//   undefined - leave reset in IDLE; registers keep power-up contents

module pacoblaze_regfile_arbiter
  import pacoblaze_regfile_arbiter_pkg::*;
#(
  parameter int DEPTH_W      = DEF_DEPTH_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  // core side
  input  logic              core_xreq,
  input  logic              core_we,
  input  logic [DEPTH_W-1:0] core_xaddr,
  input  logic [DATA_W-1:0]  core_wdata,
  output logic              core_stall,
  // host side
  input  logic              host_req,
  input  logic              host_we,
  input  logic [DEPTH_W-1:0] host_addr,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0]  host_rdata,
  output logic              host_rvalid,
  // clear sweep
  input  logic              clear_req,
  output logic              busy,
  // register file X port
  output logic              rf_we,
  output logic [DEPTH_W-1:0] rf_xaddr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic [DATA_W-1:0]  rf_xdata
);

`ifdef PACOBLAZE_CLEAR_ON_RESET_EN
  localparam arb_state_e RESET_STATE = ST_CLEAR;
`else
  localparam arb_state_e RESET_STATE = ST_IDLE;
`endif

  localparam logic [DEPTH_W-1:0] LAST_ADDR = {DEPTH_W{1'b1}};

  arb_state_e          state_q;
  logic [DEPTH_W-1:0]  clr_addr_q;
  logic [DATA_W-1:0]   host_rdata_q;
  logic [DATA_W-1:0]   host_rdata_d;
  logic                host_rvalid_q;
  logic                host_rvalid_d;

  logic                clearing;
  logic                starve_tc;
  logic                grant_host;
  logic                starve_clr;
  logic                starve_inc;

  assign clearing = (state_q == ST_CLEAR);

  // Host wins when the core is not using the port, or when it has waited
  // long enough that the core gives up one cycle. Never during a sweep.
  always_comb begin
    grant_host = !clearing && host_req && (!core_xreq || starve_tc);
  end

  // Waiting is only counted while a request is outstanding and refused;
  // the sweep holds the count at zero so the host restarts fairly after it.
  always_comb begin
    starve_clr = clearing || grant_host || !host_req;
    starve_inc = host_req && !grant_host;
  end

  pacoblaze_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr_i (starve_clr),
    .inc_i (starve_inc),
    .tc_o  (starve_tc)
  );

  // X-port mux: sweep writes zeros, else host on grant, else core.
  always_comb begin
    rf_we    = 1'b0;
    rf_xaddr = core_xaddr;
    rf_wdata = core_wdata;
    if (clearing) begin
      rf_we    = 1'b1;
      rf_xaddr = clr_addr_q;
      rf_wdata = '0;
    end else if (grant_host) begin
      rf_we    = host_we;
      rf_xaddr = host_addr;
      rf_wdata = host_wdata;
    end else begin
      rf_we    = core_xreq && core_we;
    end
  end

  // Handshake and status outputs decoded from state and the grant.
  always_comb begin
    host_gnt   = grant_host;
    core_stall = clearing || (grant_host && core_xreq);
    busy       = clearing;
  end

  // FSM: IDLE shares the port; CLEAR walks every address once, then returns.
  // A clear_req seen during CLEAR is ignored so the sweep never restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RESET_STATE;
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          clr_addr_q <= '0;
        end
      endcase
    end
  end

  // Read return: capture the file's combinational output on a read grant,
  // hold it otherwise; rvalid pulses the cycle after the grant.
  always_comb begin
    host_rvalid_d = grant_host && !host_we;
    host_rdata_d  = host_rdata_q;
    if (grant_host && !host_we) begin
      host_rdata_d = rf_xdata;
    end
  end

  // Read-return registers; reset drops a pending rvalid immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

endmodule
